// File: rtl/prog_loader.sv
// Byte-stream program loader: receives a framed image (sync, length, base, data, xor checksum)
// and writes it into the 256x8 RAM, keeping the CPU halted until a frame verifies.
module prog_loader #(
   parameter logic [7:0]  SYNC_BYTE = 8'hA5,
   parameter int unsigned TIMEOUT   = 1000,
   parameter int unsigned TO_W      = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic       ram_we,
   output logic [7:0] ram_addr,
   output logic [7:0] ram_wdata,
   output logic       cpu_run,
   output logic       load_done,
   output logic       load_err,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_BASE,
      S_DATA,
      S_CSUM
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t          state_q, state_d;
   logic [8:0]      count_q, count_d;
   logic [7:0]      ptr_q, ptr_d;
   logic [7:0]      xor_q, xor_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            we_q, we_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic            run_q, run_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic accept;
   logic timeoutHit;

   // The loader never stalls the source, so every valid byte is a transfer.
   assign accept     = rx_valid;
   assign timeoutHit = (state_q != S_IDLE) && !accept && (to_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: if (accept && rx_data == SYNC_BYTE) state_d = S_LEN;
         S_LEN:  if (accept) state_d = S_BASE;
         S_BASE: if (accept) state_d = S_DATA;
         S_DATA: if (accept && count_q == 9'd1) state_d = S_CSUM;
         S_CSUM: if (accept) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (timeoutHit) state_d = S_IDLE;
   end

   // A byte accepted in the cycle the idle counter would expire takes priority over the timeout.
   always_comb begin
      count_d = count_q;
      ptr_d   = ptr_q;
      xor_d   = xor_q;
      to_d    = to_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      run_d   = run_q;
      done_d  = done_q;
      err_d   = err_q;
      if (state_q == S_IDLE) begin
         to_d = '0;
         if (accept && rx_data == SYNC_BYTE) begin
            run_d  = 1'b0;
            done_d = 1'b0;
            err_d  = 1'b0;
         end
      end else if (accept) begin
         to_d = '0;
         unique case (state_q)
            S_LEN: count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
            S_BASE: begin
               ptr_d = rx_data;
               xor_d = 8'd0;
            end
            S_DATA: begin
               we_d    = 1'b1;
               addr_d  = ptr_q;
               wdata_d = rx_data;
               ptr_d   = ptr_q + 8'd1;
               xor_d   = xor_q ^ rx_data;
               count_d = count_q - 9'd1;
            end
            S_CSUM: begin
               if (rx_data == xor_q) begin
                  done_d = 1'b1;
                  run_d  = 1'b1;
               end else begin
                  err_d = 1'b1;
                  run_d = 1'b0;
               end
            end
            default: ;
         endcase
      end else if (timeoutHit) begin
         to_d  = '0;
         err_d = 1'b1;
         run_d = 1'b0;
      end else begin
         to_d = to_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
         ptr_q   <= '0;
         xor_q   <= '0;
         to_q    <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ptr_q   <= ptr_d;
         xor_q   <= xor_d;
         to_q    <= to_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         run_q   <= run_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      rx_ready  = 1'b1;
      busy      = (state_q != S_IDLE);
      ram_we    = we_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      cpu_run   = run_q;
      load_done = done_q;
      load_err  = err_q;
   end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected RAM writes are queued as frames are sent and a
// negedge monitor pops and compares each write; flags are checked against hand-computed values.
module tb_prog_loader;

   localparam int TO = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic       ram_we;
   logic [7:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       cpu_run;
   logic       load_done;
   logic       load_err;
   logic       busy;

   int passCount  = 0;
   int totalCount = 0;
   int cycle      = 0;

   logic [15:0] expQ[$];
   int          writeCyc[$];
   logic [15:0] expWrite;

   prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO), .TO_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_wdata(ram_wdata),
      .cpu_run  (cpu_run),
      .load_done(load_done),
      .load_err (load_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycle++;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      totalCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Flags packed as {load_done, load_err, cpu_run, busy}.
   task automatic checkFlags(input string name, input logic [3:0] exp);
      checkOutput(name, {12'd0, load_done, load_err, cpu_run, busy}, {12'd0, exp});
   endtask

   always @(negedge clk) begin
      if (ram_we === 1'b1) begin
         writeCyc.push_back(cycle);
         if (expQ.size() == 0) begin
            totalCount++;
            $display("[TB] FAIL unexpected_write: got %h@%h, expected no write", ram_wdata, ram_addr);
         end else begin
            expWrite = expQ.pop_front();
            checkOutput("ram_write", {ram_addr, ram_wdata}, expWrite);
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n);
      rx_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expectWrite(input logic [7:0] addr, input logic [7:0] data);
      expQ.push_back({addr, data});
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs", {10'd0, rx_ready, ram_we, cpu_run, load_done, load_err, busy},
                  16'b0000_0000_0010_0000);
      rst_n = 1'b1;
      idleCycles(2);

      // Basic frame, valid held high throughout
      writeCyc.delete();
      expectWrite(8'h10, 8'h11);
      expectWrite(8'h11, 8'h22);
      expectWrite(8'h12, 8'h33);
      applyStimulus(8'hA5);
      checkFlags("sync_enters_frame", 4'b0001);
      applyStimulus(8'h03);
      applyStimulus(8'h10);
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h00);
      checkFlags("frame1_done", 4'b1010);
      checkOutput("frame1_write_count", 16'(writeCyc.size()), 16'd3);
      if (writeCyc.size() == 3)
         checkOutput("frame1_consecutive", 16'(writeCyc[2] - writeCyc[0]), 16'd2);
      idleCycles(2);

      // Address wrap
      expectWrite(8'hFF, 8'hAA);
      expectWrite(8'h00, 8'h55);
      applyStimulus(8'hA5);
      applyStimulus(8'h02);
      applyStimulus(8'hFF);
      applyStimulus(8'hAA);
      applyStimulus(8'h55);
      applyStimulus(8'hFF);
      checkFlags("wrap_done", 4'b1010);
      idleCycles(2);

      // Bad checksum: data still written
      expectWrite(8'h20, 8'h7E);
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h20);
      applyStimulus(8'h7E);
      applyStimulus(8'h7F);
      checkFlags("bad_csum_err", 4'b0100);
      idleCycles(2);

      // Timeout expiry exactly after TO idle cycles
      expectWrite(8'h00, 8'h01);
      applyStimulus(8'hA5);
      applyStimulus(8'h04);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      idleCycles(TO - 1);
      checkFlags("timeout_not_yet", 4'b0001);
      idleCycles(1);
      checkFlags("timeout_expired", 4'b0100);
      idleCycles(2);

      // Byte arriving on the expiry cycle wins
      expectWrite(8'h00, 8'h01);
      expectWrite(8'h01, 8'h02);
      expectWrite(8'h02, 8'h03);
      expectWrite(8'h03, 8'h04);
      applyStimulus(8'hA5);
      applyStimulus(8'h04);
      applyStimulus(8'h00);
      applyStimulus(8'h01);
      idleCycles(TO - 1);
      applyStimulus(8'h02);
      checkFlags("late_byte_no_err", 4'b0001);
      applyStimulus(8'h03);
      applyStimulus(8'h04);
      applyStimulus(8'h04);
      checkFlags("late_byte_done", 4'b1010);
      idleCycles(2);

      // Junk in IDLE is ignored
      applyStimulus(8'h00);
      applyStimulus(8'h12);
      applyStimulus(8'hFF);
      checkFlags("junk_ignored", 4'b1010);
      expectWrite(8'h40, 8'h5A);
      applyStimulus(8'hA5);
      applyStimulus(8'h01);
      applyStimulus(8'h40);
      applyStimulus(8'h5A);
      applyStimulus(8'h5A);
      checkFlags("after_junk_done", 4'b1010);
      idleCycles(1);

      // LEN=0 means 256 bytes; XOR of 0..255 is 0
      for (int i = 0; i < 256; i++) expectWrite(8'(i), 8'(i));
      applyStimulus(8'hA5);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      for (int i = 0; i < 256; i++) applyStimulus(8'(i));
      checkFlags("len256_in_csum", 4'b0001);
      applyStimulus(8'h00);
      checkFlags("len256_done", 4'b1010);
      checkOutput("len256_queue_drained", 16'(expQ.size()), 16'd0);
      idleCycles(2);

      // New sync drops flags; reset mid-DATA kills writes
      applyStimulus(8'hA5);
      checkFlags("resync_clears", 4'b0001);
      expectWrite(8'h80, 8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h80);
      applyStimulus(8'h01);
      rst_n = 1'b0;
      applyStimulus(8'h02);
      checkOutput("reset_mid_we", {15'd0, ram_we}, 16'd0);
      checkFlags("reset_mid_flags", 4'b0000);
      idleCycles(2);
      checkOutput("reset_hold_we", {15'd0, ram_we}, 16'd0);
      rst_n = 1'b1;
      idleCycles(3);
      checkFlags("post_reset_flags", 4'b0000);
      checkOutput("final_queue_empty", 16'(expQ.size()), 16'd0);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream program loader sitting directly upstream of the 256x8 RAM.
- Receives a framed program image over a valid/ready byte interface and writes it into RAM through the RAM write port (we/addr2/in).
- Holds the CPU halted until a valid frame completes, then releases it via cpu_run.
- Provides the boot path for the 8-bit CPU.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000, maximum idle clocks between bytes inside a frame before abort; must be at least 1.
- TO_W, 16, width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid && rx_ready at posedge.
- ram_we  out  1  RAM write enable (to RAM we).
- ram_addr  out  8  RAM write address (to RAM addr2).
- ram_wdata  out  8  RAM write data (to RAM in).
- cpu_run  out  1  1 = CPU may execute; 0 = CPU held.
- load_done  out  1  last frame loaded with good checksum.
- load_err  out  1  last frame aborted (bad checksum or timeout).
- busy  out  1  frame in progress (state not IDLE).

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=IDLE.
  - All outputs 0 except rx_ready=1.
  - Internal counters/checksum cleared.
  - Reset mid-frame abandons the frame; RAM contents are not touched further.
- Frame format, in order: SYNC_BYTE, LEN, BASE, LEN data bytes, CSUM.
  - LEN=0 means 256 data bytes.
  - CSUM must equal the XOR of all data bytes; LEN and BASE are excluded.
- rx_ready=1 in every state; the loader never stalls the source.
- States and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> LEN; clear cpu_run, load_done, load_err. Any other byte is discarded with no flag change.
  - LEN: latch count (0 -> 256, 9-bit counter) -> BASE.
  - BASE: latch address pointer, clear xor accumulator -> DATA.
  - DATA: each accepted byte produces exactly one write:
    - ram_we=1 for exactly one cycle, in the cycle after acceptance.
    - ram_addr and ram_wdata are registered with that write.
    - Pointer increments mod 256 (0xFF wraps to 0x00).
    - xor ^= byte; count decrements.
    - Go to CSUM after the byte that takes count to 0.
  - CSUM: accepted byte == xor -> IDLE with load_done=1, cpu_run=1. Otherwise -> IDLE with load_err=1, cpu_run=0.
- Write pulses are never merged or dropped. Back-to-back accepted data bytes give ram_we high on consecutive cycles.
- ram_addr and ram_wdata hold their last value when ram_we=0.
- Data is written before CSUM is verified. A bad frame leaves partially written RAM; cpu_run=0 protects execution.
- Timeout (states LEN, BASE, DATA, CSUM only):
  - Counter clears on each accepted byte and on frame entry; increments every cycle without an accepted byte.
  - On reaching TIMEOUT: -> IDLE, load_err=1, cpu_run=0.
  - If a byte is accepted in the same cycle the counter would reach TIMEOUT, the byte wins and the counter clears.
- Flags and cpu_run are level outputs. They persist until the next SYNC_BYTE is accepted in IDLE or until reset.
- A SYNC_BYTE value arriving inside a frame is ordinary data.
- busy=1 whenever state != IDLE.

Test Plan:
- Reset, then frame A5,03,10,11,22,33,CSUM=00 with rx_valid held high -> writes 11@10, 22@11, 33@12 on three consecutive ram_we cycles; load_done=1, cpu_run=1, load_err=0.
- Frame A5,02,FF,AA,55,FF -> writes AA@FF, 55@00 (address wrap); load_done=1.
- Frame A5,01,20,7E,7F (bad CSUM) -> write 7E@20 occurs; load_err=1, cpu_run=0, load_done=0.
- Frame A5,04,00,01 then rx_valid=0 for TIMEOUT cycles -> state returns to IDLE exactly at TIMEOUT; load_err=1. Repeat with a byte arriving on cycle TIMEOUT-1 -> no error.
- Bytes 00,12,FF in IDLE, then a good frame -> leading bytes ignored with no writes; then A5 with LEN=00 and 256 bytes 0..255 plus CSUM=00 -> 256 writes; load_done=1.
- Good frame completes (cpu_run=1), then A5 sent -> cpu_run and load_done drop the next cycle; rst_n=0 mid-DATA -> ram_we stays 0 from the reset cycle on and all flags read 0.
